// File: rtl/rr_grant_sched.sv
// rr_grant_sched: eight-way round-robin arbiter driving a registered one-hot grant and index.
// Define ARB_HOLD_LIMIT_EN to compile in the MAX_HOLD forced-rotation feature with a preempt pulse.
module rr_grant_sched #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_vld,
  output logic       preempt
);

  localparam int unsigned N  = 8;
  localparam int unsigned IW = 3;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  if (MAX_HOLD < 2 || MAX_HOLD > 256) begin : g_bad_max_hold
    $error("rr_grant_sched: MAX_HOLD must be in 2..256");
  end

  // Returns {found, index} of the first set bit at or after start, wrapping modulo 8.
  function automatic logic [IW:0] rr_pick(input logic [N-1:0] v, input logic [IW-1:0] start);
    logic [IW:0]   res;
    logic [IW-1:0] pos;
    res = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = start + IW'(k);
      if (v[pos]) res = {1'b1, pos};
    end
    return res;
  endfunction

  logic [0:0]    state, state_nxt;
  logic [IW-1:0] ptr, ptr_nxt;
  logic [IW-1:0] idx_nxt;
  logic          vld_nxt;
  logic          pre_nxt;
  logic [N-1:0]  gnt_nxt;
  logic [N-1:0]  others;
  logic          holder_req;
  logic [IW:0]   pick_all;
  logic [IW:0]   pick_oth;

`ifdef ARB_HOLD_LIMIT_EN
  localparam int unsigned   HCW      = $clog2(MAX_HOLD);
  localparam logic [HCW-1:0] HOLD_MAX = HCW'(MAX_HOLD - 1);

  logic [HCW-1:0] hold_cnt, hold_cnt_nxt;
`endif

  // The holder is masked out so a re-scan never re-grants it on the same edge.
  assign others     = req & ~gnt;
  assign holder_req = |(req & gnt);
  assign pick_all   = rr_pick(req, ptr);
  assign pick_oth   = rr_pick(others, ptr);

  // Next-state and next-output decode.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    idx_nxt   = gnt_idx;
    vld_nxt   = gnt_vld;
    pre_nxt   = 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
    hold_cnt_nxt = hold_cnt;
`endif
    case (state)
      IDLE: begin
        if (pick_all[IW]) begin
          state_nxt = BUSY;
          idx_nxt   = pick_all[IW-1:0];
          vld_nxt   = 1'b1;
          ptr_nxt   = pick_all[IW-1:0] + IW'(1);
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_nxt = '0;
`endif
        end
      end
      BUSY: begin
        if (!holder_req) begin
          if (pick_oth[IW]) begin
            idx_nxt = pick_oth[IW-1:0];
            ptr_nxt = pick_oth[IW-1:0] + IW'(1);
          end else begin
            state_nxt = IDLE;
            idx_nxt   = '0;
            vld_nxt   = 1'b0;
          end
`ifdef ARB_HOLD_LIMIT_EN
          hold_cnt_nxt = '0;
        end else if (hold_cnt == HOLD_MAX) begin
          // Saturated holder yields only when someone else is waiting.
          if (pick_oth[IW]) begin
            idx_nxt      = pick_oth[IW-1:0];
            ptr_nxt      = pick_oth[IW-1:0] + IW'(1);
            pre_nxt      = 1'b1;
            hold_cnt_nxt = '0;
          end
        end else begin
          hold_cnt_nxt = hold_cnt + HCW'(1);
`endif
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
        vld_nxt   = 1'b0;
      end
    endcase
    gnt_nxt = vld_nxt ? (N'(1) << idx_nxt) : '0;
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ptr     <= '0;
      gnt     <= '0;
      gnt_idx <= '0;
      gnt_vld <= 1'b0;
      preempt <= 1'b0;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= '0;
`endif
    end else begin
      state   <= state_nxt;
      ptr     <= ptr_nxt;
      gnt     <= gnt_nxt;
      gnt_idx <= idx_nxt;
      gnt_vld <= vld_nxt;
      preempt <= pre_nxt;
`ifdef ARB_HOLD_LIMIT_EN
      hold_cnt <= hold_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_rr_grant_sched.sv
// Self-checking bench for rr_grant_sched: per-scenario tasks push expected grants to a
// scoreboard queue as each req pattern is driven and pop/compare after the clock edge.
module tb_rr_grant_sched;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       vld;
    logic       pre;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_vld;
  logic       preempt;

  int checks = 0;
  int passed = 0;
  exp_t exp_q[$];

  rr_grant_sched #(.MAX_HOLD(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  function automatic exp_t mk(input int idx, input logic vld, input logic pre);
    exp_t e;
    e.idx = vld ? 3'(idx) : 3'd0;
    e.gnt = vld ? (8'd1 << e.idx) : 8'h00;
    e.vld = vld;
    e.pre = pre;
    return e;
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    req   = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== 13'd0)
      $display("FAIL reset: gnt=%h idx=%0d vld=%b pre=%b, required all zero", gnt, gnt_idx, gnt_vld, preempt);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_rotate;
    logic [7:0] rq[$];
    exp_t       ex[$];
    exp_t       e;
    logic [7:0] m;
    m = 8'hFF;
    rq.push_back(m); ex.push_back(mk(0, 1'b1, 1'b0));
    for (int i = 0; i < 8; i++) begin
      rq.push_back(m); ex.push_back(mk(i, 1'b1, 1'b0));
      m[i] = 1'b0;
      rq.push_back(m); ex.push_back(i < 7 ? mk(i + 1, 1'b1, 1'b0) : mk(0, 1'b0, 1'b0));
    end
    rq.push_back(8'h81); ex.push_back(mk(0, 1'b1, 1'b0));
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
    for (int k = 0; k < rq.size(); k++) begin
      req = rq[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
        $display("FAIL rotate step %0d: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
                 k, gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
      else passed++;
    end
  endtask

  task automatic test_single;
    logic [7:0] rq[$];
    exp_t       ex[$];
    exp_t       e;
    rq.push_back(8'h20); ex.push_back(mk(5, 1'b1, 1'b0));
    rq.push_back(8'h20); ex.push_back(mk(5, 1'b1, 1'b0));
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
    for (int k = 0; k < rq.size(); k++) begin
      req = rq[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
        $display("FAIL single step %0d: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
                 k, gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
      else passed++;
    end
  endtask

  task automatic test_fairness;
    logic [7:0] rq[$];
    exp_t       ex[$];
    exp_t       e;
    rq.push_back(8'h08); ex.push_back(mk(3, 1'b1, 1'b0));
    rq.push_back(8'h89); ex.push_back(mk(3, 1'b1, 1'b0));
    rq.push_back(8'h81); ex.push_back(mk(7, 1'b1, 1'b0));
    rq.push_back(8'h81); ex.push_back(mk(7, 1'b1, 1'b0));
    rq.push_back(8'h09); ex.push_back(mk(0, 1'b1, 1'b0));
    rq.push_back(8'h08); ex.push_back(mk(3, 1'b1, 1'b0));
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
    for (int k = 0; k < rq.size(); k++) begin
      req = rq[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
        $display("FAIL fairness step %0d: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
                 k, gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
      else passed++;
    end
  endtask

  task automatic test_hold;
    logic [7:0] rq[$];
    exp_t       ex[$];
    exp_t       e;
`ifdef ARB_HOLD_LIMIT_EN
    rq.push_back(8'h04); ex.push_back(mk(2, 1'b1, 1'b0));
    for (int i = 0; i < 3; i++) begin
      rq.push_back(8'h44); ex.push_back(mk(2, 1'b1, 1'b0));
    end
    rq.push_back(8'h44); ex.push_back(mk(6, 1'b1, 1'b1));
    rq.push_back(8'h44); ex.push_back(mk(6, 1'b1, 1'b0));
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
    rq.push_back(8'h04); ex.push_back(mk(2, 1'b1, 1'b0));
    for (int i = 0; i < 12; i++) begin
      rq.push_back(8'h04); ex.push_back(mk(2, 1'b1, 1'b0));
    end
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
`else
    rq.push_back(8'h02); ex.push_back(mk(1, 1'b1, 1'b0));
    for (int i = 0; i < 300; i++) begin
      rq.push_back(8'hFF); ex.push_back(mk(1, 1'b1, 1'b0));
    end
    rq.push_back(8'h00); ex.push_back(mk(0, 1'b0, 1'b0));
`endif
    for (int k = 0; k < rq.size(); k++) begin
      req = rq[k];
      exp_q.push_back(ex[k]);
      @(posedge clk); #1;
      e = exp_q.pop_front();
      checks++;
      if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
        $display("FAIL hold step %0d: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
                 k, gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
      else passed++;
    end
  endtask

  task automatic test_async_reset;
    exp_t e;
    req = 8'h10;
    exp_q.push_back(mk(4, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_vld} !== {e.gnt, e.idx, e.vld})
      $display("FAIL async_pre: gnt=%h idx=%0d vld=%b, required gnt=%h idx=%0d vld=%b",
               gnt, gnt_idx, gnt_vld, e.gnt, e.idx, e.vld);
    else passed++;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== 13'd0)
      $display("FAIL async_clear: gnt=%h idx=%0d vld=%b pre=%b, required all zero", gnt, gnt_idx, gnt_vld, preempt);
    else passed++;
    req = 8'h11;
    #1;
    rst_n = 1'b1;
    exp_q.push_back(mk(0, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
      $display("FAIL async_after: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
               gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
    else passed++;
    req = 8'h10;
    exp_q.push_back(mk(4, 1'b1, 1'b0));
    @(posedge clk); #1;
    e = exp_q.pop_front();
    checks++;
    if ({gnt, gnt_idx, gnt_vld, preempt} !== {e.gnt, e.idx, e.vld, e.pre})
      $display("FAIL async_next: gnt=%h idx=%0d vld=%b pre=%b, required gnt=%h idx=%0d vld=%b pre=%b",
               gnt, gnt_idx, gnt_vld, preempt, e.gnt, e.idx, e.vld, e.pre);
    else passed++;
    req = 8'h00;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_rotate();
    test_single();
    test_fairness();
    test_hold();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
